// File: rtl/nn_pkg.sv
// Shared types and defaults for the single-neuron control path.
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_DRAIN,
      S_CAPTURE,
      S_HOLD
   } state_e;

   localparam int ACC_W_DEF   = 18;
   localparam int DATA_W_DEF  = 8;
   localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/neuron_sequencer_if.sv
// Neuron-side strobes/address plus the result valid/ready handshake.
interface neuron_sequencer_if #(
   parameter int ADDR_W = 4,
   parameter int ACC_W  = 18
);
   logic                     mem_en;
   logic [ADDR_W-1:0]        mem_addr;
   logic                     push_en;
   logic                     mac_en;
   logic                     mac_clr;
   logic signed [ACC_W-1:0]  mac_out;
   logic signed [ACC_W-1:0]  result;
   logic                     result_valid;
   logic                     result_ready;

   modport master (
      output mem_en, mem_addr, push_en, mac_en, mac_clr, result, result_valid,
      input  mac_out, result_ready
   );

   modport slave (
      input  mem_en, mem_addr, push_en, mac_en, mac_clr, result, result_valid,
      output mac_out, result_ready
   );
endinterface

// File: rtl/en_delay_line.sv
// Delays mem_en by DEPTH cycles to line mac_en/push_en up with memory data.
module en_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic din,
   output logic dout
);
   logic [DEPTH-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = DEPTH'({sr_q, din});
      if (flush) sr_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= sr_d;
   end

   assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/neuron_sequencer.sv
// Run sequencer for one neuron: clear, fetch N_INPUTS products, drain, capture,
// then hold the (optionally ReLU'd) result under valid/ready.
module neuron_sequencer
   import nn_pkg::*;
#(
   parameter int N_INPUTS = 16,
   parameter int ADDR_W   = 4,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int MEM_LAT  = 1,
   parameter int RELU     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   neuron_sequencer_if.master   bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_INPUTS - 1);
   localparam int                DRAIN_W    = $clog2(MAX_MEM_LAT + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LAT);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DRAIN_W-1:0]      drain_q, drain_d;
   logic                    mem_en_q, mem_en_d;
   logic                    mac_clr_q, mac_clr_d;
   logic                    busy_q, busy_d;
   logic signed [ACC_W-1:0] result_q, result_d;
   logic                    valid_q, valid_d;
   logic                    run_abort;
   logic                    mac_strobe;

   assign run_abort = abort && busy_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      drain_d   = drain_q;
      mem_en_d  = 1'b0;
      mac_clr_d = 1'b0;
      result_d  = result_q;
      valid_d   = valid_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_CLEAR;
               mac_clr_d = 1'b1;
            end
         end
         S_CLEAR: begin
            state_d  = S_FETCH;
            mem_en_d = 1'b1;
            addr_d   = '0;
         end
         S_FETCH: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               mem_en_d = 1'b1;
               addr_d   = addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = S_CAPTURE;
            else                       drain_d = drain_q + 1'b1;
         end
         S_CAPTURE: begin
            state_d  = S_HOLD;
            result_d = ((RELU != 0) && bus.mac_out[ACC_W-1]) ? '0 : bus.mac_out;
            valid_d  = 1'b1;
         end
         S_HOLD: begin
            // A same-cycle start on the accepting handshake chains the next run.
            if (valid_q && bus.result_ready) begin
               valid_d = 1'b0;
               if (start) begin
                  state_d   = S_CLEAR;
                  mac_clr_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (run_abort) begin
         state_d   = S_IDLE;
         addr_d    = addr_q;
         mem_en_d  = 1'b0;
         mac_clr_d = 1'b0;
         result_d  = result_q;
         valid_d   = valid_q;
      end

      busy_d = !(state_d inside {S_IDLE, S_HOLD});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         drain_q   <= '0;
         mem_en_q  <= 1'b0;
         mac_clr_q <= 1'b0;
         busy_q    <= 1'b0;
         result_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         drain_q   <= drain_d;
         mem_en_q  <= mem_en_d;
         mac_clr_q <= mac_clr_d;
         busy_q    <= busy_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
      end
   end

   en_delay_line #(.DEPTH(MEM_LAT)) u_en_delay (
      .clk   (clk),
      .rst_n (reset),
      .flush (run_abort),
      .din   (mem_en_q),
      .dout  (mac_strobe)
   );

   assign bus.mem_en       = mem_en_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mac_clr      = mac_clr_q;
   assign bus.mac_en       = mac_strobe;
   assign bus.push_en      = mac_strobe;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign busy             = busy_q;
endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: two instances (MEM_LAT=1 ReLU, MEM_LAT=3 no ReLU)
// driving a behavioural memory+MAC, results checked against a sum-of-products model.
module tb_neuron_sequencer;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0] start_v, abort_v, ready_v, busy_v;
   logic [1:0] mem_en_v, mac_en_v, push_en_v, mac_clr_v, valid_v;
   logic [3:0]  addr_v   [2];
   logic [17:0] result_v [2];
   logic [17:0] acc      [2];

   neuron_sequencer_if #(.ADDR_W(4), .ACC_W(18)) bus1 ();
   neuron_sequencer_if #(.ADDR_W(4), .ACC_W(18)) bus3 ();

   neuron_sequencer #(.N_INPUTS(N), .ADDR_W(4), .ACC_W(18), .MEM_LAT(1), .RELU(1)) dut1 (
      .clk(clk), .reset(rst_n), .start(start_v[0]), .abort(abort_v[0]), .busy(busy_v[0]), .bus(bus1));
   neuron_sequencer #(.N_INPUTS(N), .ADDR_W(4), .ACC_W(18), .MEM_LAT(3), .RELU(0)) dut3 (
      .clk(clk), .reset(rst_n), .start(start_v[1]), .abort(abort_v[1]), .busy(busy_v[1]), .bus(bus3));

   assign mem_en_v  = {bus3.mem_en,       bus1.mem_en};
   assign mac_en_v  = {bus3.mac_en,       bus1.mac_en};
   assign push_en_v = {bus3.push_en,      bus1.push_en};
   assign mac_clr_v = {bus3.mac_clr,      bus1.mac_clr};
   assign valid_v   = {bus3.result_valid, bus1.result_valid};
   assign addr_v[0] = bus1.mem_addr;
   assign addr_v[1] = bus3.mem_addr;
   assign result_v[0] = bus1.result;
   assign result_v[1] = bus3.result;
   assign bus1.mac_out = acc[0];
   assign bus3.mac_out = acc[1];
   assign bus1.result_ready = ready_v[0];
   assign bus3.result_ready = ready_v[1];

   // Memory with MEM_LAT read latency feeding a registered MAC (tap 0 for lat 1, tap 2 for lat 3)
   int wmem [N];
   int xmem [N];
   int mac_cnt [2];
   int push_cnt [2];
   int env_err;
   logic [3:0] pa [2][4];
   logic [3:0] pv [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            acc[i] <= '0;
            pv[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (mac_clr_v[i]) acc[i] <= '0;
            else if (mac_en_v[i])
               acc[i] <= acc[i] + 18'(wmem[pa[i][2*i]] * xmem[pa[i][2*i]]);
            if (mac_en_v[i] && !pv[i][2*i]) env_err <= env_err + 1;
            if (mac_en_v[i])  mac_cnt[i]  <= mac_cnt[i] + 1;
            if (push_en_v[i]) push_cnt[i] <= push_cnt[i] + 1;
            pv[i] <= {pv[i][2:0], mem_en_v[i]};
            pa[i][0] <= addr_v[i];
            for (int j = 1; j < 4; j++) pa[i][j] <= pa[i][j-1];
         end
      end
   end

   int tests = 0;
   int fails = 0;
   logic [17:0] last_exp;

   function automatic logic [17:0] model_result(input bit relu);
      int s;
      s = 0;
      for (int a = 0; a < N; a++) s += wmem[a] * xmem[a];
      if (relu && s < 0) s = 0;
      return 18'(s);
   endfunction

   task automatic fill_random();
      for (int a = 0; a < N; a++) begin
         wmem[a] = int'($urandom_range(40)) - 20;
         xmem[a] = int'($urandom_range(40)) - 20;
      end
   endtask

   task automatic accept(input int inst);
      ready_v[inst] = 1'b1;
      @(negedge clk);
      ready_v[inst] = 1'b0;
   endtask

   // Starts a run and observes it up to result_valid (no checking here)
   task automatic do_run(input int inst, input bit with_ready, input bit noise,
                         output int edges, output int addr_err, output int macs,
                         output int pushes, output int lag, output bit clr_first);
      int m0, p0, idx, first_mem, first_mac;
      m0 = mac_cnt[inst]; p0 = push_cnt[inst];
      idx = 0; addr_err = 0; first_mem = -1; first_mac = -1;
      start_v[inst] = 1'b1;
      ready_v[inst] = with_ready;
      @(negedge clk);
      start_v[inst] = 1'b0;
      ready_v[inst] = 1'b0;
      edges = 1;
      clr_first = mac_clr_v[inst];
      while (!valid_v[inst] && edges < 200) begin
         if (mem_en_v[inst]) begin
            if (addr_v[inst] != 4'(idx)) addr_err++;
            if (first_mem < 0) first_mem = edges;
            idx++;
         end
         if (mac_en_v[inst] && first_mac < 0) first_mac = edges;
         start_v[inst] = noise && (edges == 5 || edges == 19);
         @(negedge clk);
         edges++;
      end
      start_v[inst] = 1'b0;
      if (idx != N) addr_err++;
      macs   = mac_cnt[inst] - m0;
      pushes = push_cnt[inst] - p0;
      lag    = first_mac - first_mem;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_v = '0; abort_v = '0; ready_v = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         tests++;
         if ({mem_en_v[i], addr_v[i], push_en_v[i], mac_en_v[i], mac_clr_v[i], busy_v[i], valid_v[i]} !== 10'd0) begin
            fails++;
            $display("FAIL reset_outputs[%0d]: got %b required 0", i,
                     {mem_en_v[i], addr_v[i], push_en_v[i], mac_en_v[i], mac_clr_v[i], busy_v[i], valid_v[i]});
         end
         tests++;
         if (result_v[i] !== 18'd0) begin
            fails++; $display("FAIL reset_result[%0d]: got %h required 0", i, result_v[i]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int edges, aerr, macs, pushes, lag;
      bit clr;
      logic [17:0] exp;
      for (int a = 0; a < N; a++) begin wmem[a] = a + 1; xmem[a] = 1; end
      exp = model_result(1'b1);
      do_run(0, 1'b0, 1'b0, edges, aerr, macs, pushes, lag, clr);
      tests++; if (edges != N + 1 + 4) begin fails++; $display("FAIL basic_latency: got %0d required %0d", edges, N + 5); end
      tests++; if (aerr != 0) begin fails++; $display("FAIL basic_addr_seq: got %0d errors required 0", aerr); end
      tests++; if (macs != N) begin fails++; $display("FAIL basic_mac_pulses: got %0d required %0d", macs, N); end
      tests++; if (pushes != N) begin fails++; $display("FAIL basic_push_pulses: got %0d required %0d", pushes, N); end
      tests++; if (clr !== 1'b1) begin fails++; $display("FAIL basic_mac_clr: got %b required 1", clr); end
      tests++; if (lag != 1) begin fails++; $display("FAIL basic_mac_lag: got %0d required 1", lag); end
      tests++; if (result_v[0] !== exp) begin fails++; $display("FAIL basic_result: got %0d required %0d", result_v[0], exp); end
      tests++; if (busy_v[0] !== 1'b0) begin fails++; $display("FAIL basic_busy_hold: got %b required 0", busy_v[0]); end
      accept(0);
      tests++; if ({valid_v[0], busy_v[0]} !== 2'b00) begin fails++; $display("FAIL basic_handshake: got %b required 00", {valid_v[0], busy_v[0]}); end
   endtask

   task automatic test_relu();
      int edges, aerr, macs, pushes, lag;
      bit clr;
      for (int a = 0; a < N; a++) begin wmem[a] = (a == 0) ? -5 : -3; xmem[a] = 1; end
      do_run(0, 1'b0, 1'b0, edges, aerr, macs, pushes, lag, clr);
      tests++; if (result_v[0] !== model_result(1'b1)) begin fails++; $display("FAIL relu_clamp: got %h required %h", result_v[0], model_result(1'b1)); end
      do_run(1, 1'b0, 1'b0, edges, aerr, macs, pushes, lag, clr);
      tests++; if (result_v[1] !== model_result(1'b0)) begin fails++; $display("FAIL relu_off: got %h required %h", result_v[1], model_result(1'b0)); end
      tests++; if (edges != N + 3 + 4) begin fails++; $display("FAIL lat3_latency: got %0d required %0d", edges, N + 7); end
      tests++; if (lag != 3) begin fails++; $display("FAIL lat3_mac_lag: got %0d required 3", lag); end
      tests++; if (macs != N || env_err != 0) begin fails++; $display("FAIL lat3_mac_align: got %0d pulses %0d misaligned required %0d/0", macs, env_err, N); end
      accept(0);
      accept(1);
   endtask

   task automatic test_backpressure();
      int edges, aerr, macs, pushes, lag, bad;
      bit clr;
      logic [17:0] exp;
      fill_random();
      exp = model_result(1'b1);
      do_run(0, 1'b0, 1'b0, edges, aerr, macs, pushes, lag, clr);
      tests++; if (result_v[0] !== exp) begin fails++; $display("FAIL bp_result: got %h required %h", result_v[0], exp); end
      bad = 0;
      repeat (10) begin
         start_v[0] = $urandom_range(1);
         @(negedge clk);
         if (result_v[0] !== exp || valid_v[0] !== 1'b1) bad++;
      end
      start_v[0] = 1'b0;
      tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles required 0", bad); end
      fill_random();
      exp = model_result(1'b1);
      do_run(0, 1'b1, 1'b0, edges, aerr, macs, pushes, lag, clr);
      tests++; if (clr !== 1'b1) begin fails++; $display("FAIL b2b_mac_clr: got %b required 1", clr); end
      tests++; if (edges != N + 5) begin fails++; $display("FAIL b2b_latency: got %0d required %0d", edges, N + 5); end
      tests++; if (result_v[0] !== exp || aerr != 0) begin fails++; $display("FAIL b2b_result: got %h (%0d addr errs) required %h", result_v[0], aerr, exp); end
      last_exp = exp;
   endtask

   task automatic test_abort();
      int cnt, guard, m_run, m_post;
      abort_v[0] = 1'b1;
      @(negedge clk);
      abort_v[0] = 1'b0;
      tests++; if ({valid_v[0], busy_v[0]} !== 2'b10 || result_v[0] !== last_exp) begin
         fails++; $display("FAIL abort_in_hold: got v/b=%b res=%h required 10 res=%h", {valid_v[0], busy_v[0]}, result_v[0], last_exp);
      end
      accept(0);
      fill_random();
      m_run = mac_cnt[0];
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      cnt = 0; guard = 0;
      while (cnt < 5 && guard < 40) begin
         if (mem_en_v[0]) cnt++;
         if (cnt < 5) begin @(negedge clk); guard++; end
      end
      tests++; if (addr_v[0] !== 4'd4) begin fails++; $display("FAIL abort_at_addr: got %0d required 4", addr_v[0]); end
      abort_v[0] = 1'b1;
      @(negedge clk);
      abort_v[0] = 1'b0;
      tests++; if ({mem_en_v[0], busy_v[0], valid_v[0]} !== 3'b000) begin
         fails++; $display("FAIL abort_stop: got mem_en/busy/valid=%b required 000", {mem_en_v[0], busy_v[0], valid_v[0]});
      end
      tests++; if (result_v[0] !== last_exp) begin fails++; $display("FAIL abort_result_kept: got %h required %h", result_v[0], last_exp); end
      m_post = mac_cnt[0];
      repeat (6) @(negedge clk);
      tests++; if (mac_cnt[0] != m_post || m_post - m_run != 4) begin
         fails++; $display("FAIL abort_flush: got %0d total, %0d late pulses required 4, 0", m_post - m_run, mac_cnt[0] - m_post);
      end
      start_v[0] = 1'b1; abort_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0; abort_v[0] = 1'b1;
      tests++; if ({mac_clr_v[0], busy_v[0]} !== 2'b11) begin fails++; $display("FAIL idle_start_abort: got %b required 11", {mac_clr_v[0], busy_v[0]}); end
      @(negedge clk);
      abort_v[0] = 1'b0;
      tests++; if ({mac_clr_v[0], busy_v[0]} !== 2'b00) begin fails++; $display("FAIL clear_abort: got %b required 00", {mac_clr_v[0], busy_v[0]}); end
   endtask

   task automatic test_reset_mid();
      int edges, aerr, macs, pushes, lag, guard;
      bit clr, seen;
      logic [17:0] exp;
      fill_random();
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      seen = 1'b0; guard = 0;
      while (!(seen && !mem_en_v[0]) && guard < 60) begin
         if (mem_en_v[0]) seen = 1'b1;
         @(negedge clk); guard++;
      end
      #2 rst_n = 1'b0;
      #1;
      tests++; if ({mem_en_v[0], push_en_v[0], mac_en_v[0], mac_clr_v[0], busy_v[0], valid_v[0], addr_v[0]} !== 10'd0 || result_v[0] !== 18'd0) begin
         fails++; $display("FAIL reset_mid_drain: got %b res=%h required 0", {mem_en_v[0], busy_v[0], valid_v[0], addr_v[0]}, result_v[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_random();
      exp = model_result(1'b1);
      do_run(0, 1'b0, 1'b0, edges, aerr, macs, pushes, lag, clr);
      tests++; if (edges != N + 5 || macs != N || aerr != 0) begin
         fails++; $display("FAIL post_reset_run: got lat %0d macs %0d addr errs %0d required %0d %0d 0", edges, macs, aerr, N + 5, N);
      end
      tests++; if (result_v[0] !== exp) begin fails++; $display("FAIL post_reset_result: got %h required %h", result_v[0], exp); end
      accept(0);
   endtask

   task automatic test_ignored_start();
      int edges, aerr, macs, pushes, lag, extra;
      bit clr;
      logic [17:0] exp;
      fill_random();
      exp = model_result(1'b0);
      do_run(1, 1'b0, 1'b1, edges, aerr, macs, pushes, lag, clr);
      tests++; if (edges != N + 7 || macs != N || lag != 3) begin
         fails++; $display("FAIL noise_run: got lat %0d macs %0d lag %0d required %0d %0d 3", edges, macs, lag, N + 7, N);
      end
      tests++; if (result_v[1] !== exp) begin fails++; $display("FAIL noise_result: got %h required %h", result_v[1], exp); end
      accept(1);
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (valid_v[1] || busy_v[1]) extra++;
      end
      tests++; if (extra != 0) begin fails++; $display("FAIL noise_single_result: got %0d active cycles required 0", extra); end
      tests++; if (env_err != 0) begin fails++; $display("FAIL mac_alignment: got %0d misaligned pulses required 0", env_err); end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      env_err = 0;
      test_reset();
      test_basic();
      test_relu();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_ignored_start();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
Control-side initiator for the single-neuron datapath (top_one_neuron). On a start request it generates the neuron's mem_en, push_en and mac_en strobes and the weight/input memory address. It clears the accumulator, steps through N_INPUTS products and captures the 18-bit MAC result. It then optionally applies ReLU and holds the result under a valid/ready handshake for the next layer or a host.

Parameters:
N_INPUTS, 16, number of input/weight pairs accumulated per run (>=1)
ADDR_W, 4, memory address width; must satisfy 2**ADDR_W >= N_INPUTS
ACC_W, 18, width of neuron mac_out and of result
MEM_LAT, 1, read latency in cycles from mem_en/mem_addr to data at the MAC (1..4)
RELU, 1, 1 = clamp negative result to 0; 0 = pass mac_out unchanged

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  run request; sampled only in IDLE or HOLD
abort  in  1  synchronous cancel of a run in progress
mac_out  in  ACC_W  signed accumulator value from neuron
mem_en  out  1  memory read enable
mem_addr  out  ADDR_W  read address, weights/inputs index
push_en  out  1  shift current input sample into the neuron
mac_en  out  1  accumulate current product
mac_clr  out  1  synchronous clear of the neuron accumulator
busy  out  1  high in every state except IDLE and HOLD
result  out  ACC_W  captured (and ReLU'd) neuron output, signed
result_valid  out  1  result available
result_ready  in  1  consumer accepts result

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; address counter and enable delay line cleared.
- States: IDLE, CLEAR, FETCH, DRAIN, CAPTURE, HOLD.
- IDLE: start=1 -> CLEAR.
- CLEAR (1 cycle): mac_clr=1 -> FETCH.
- FETCH (N_INPUTS cycles): mem_en=1; mem_addr=0,1,...,N_INPUTS-1, one per cycle. After the cycle with address N_INPUTS-1 -> DRAIN.
- mac_en and push_en are mem_en delayed by exactly MEM_LAT cycles, so exactly N_INPUTS pulses occur per run.
- DRAIN: MEM_LAT+1 cycles, covering the delay line plus the MAC register -> CAPTURE.
- CAPTURE (1 cycle): result <= (RELU && mac_out[ACC_W-1]) ? 0 : mac_out; result_valid set at the next edge -> HOLD.
- HOLD: result and result_valid are stable until result_valid && result_ready.
  - On handshake: result_valid cleared; start=1 in the same cycle -> CLEAR (back-to-back run, no bubble); otherwise -> IDLE.
  - start without handshake in HOLD is ignored.
- Latency: result_valid rises N_INPUTS+MEM_LAT+4 edges after the edge that samples start. Defaults give 21.
- start is ignored in CLEAR, FETCH, DRAIN and CAPTURE.
- abort=1 in CLEAR, FETCH, DRAIN or CAPTURE:
  - next state IDLE.
  - mem_en deasserted immediately; delay line flushed so no further mac_en/push_en.
  - result and result_valid unchanged (the previous result is not overwritten).
- abort in IDLE or HOLD has no effect.
- abort and start together: abort wins when busy; only start is considered in IDLE/HOLD.
- mem_addr holds its last value when mem_en=0. It never exceeds N_INPUTS-1 and never wraps mid-run.
- Reset mid-run returns to IDLE at once, with all outputs 0 including result_valid.

Decomposition:
- Shared package nn_pkg:
  - state enum (IDLE..HOLD)
  - ACC_W_DEF=18, DATA_W_DEF=8
  - MAX_MEM_LAT=4
- One sub-module, en_delay_line: a MEM_LAT-deep shift register with an async active-low reset and a synchronous flush. It produces mac_en and push_en from mem_en.

Test Plan:
- Basic run with the bench model of the neuron (memory returning weight=addr+1, input=1, MEM_LAT=1), start pulse -> addresses 0..15 in FETCH; 16 mac_en pulses; result_valid at edge 21; result=136; busy low at HOLD.
- RELU=1, memory giving products summing to -50 -> result=0. RELU=0 with the same data -> result=-50 (18'h3FFCE).
- result_ready held 0 for 10 cycles -> result stable. Then ready=1 with start=1 in the same cycle -> mac_clr on the next edge; second result_valid 21 edges after that handshake.
- abort at the 5th FETCH cycle -> mem_en low the next cycle; no mac_en after the delay line drains; state IDLE; earlier result and result_valid unchanged.
- reset=0 asserted asynchronously mid-DRAIN -> all outputs 0 immediately. After release, start -> a full, correct run.
- start pulses during FETCH and DRAIN -> ignored; exactly one result per accepted start; MEM_LAT=3 variant -> mac_en lags mem_en by 3 cycles and latency is 23.
